// File: rtl/bcd_countdown.sv
// Two-digit BCD countdown timer: loads from switches, counts down once per
// prescaled tick to 00, pulses done, and drives two active-low 7-seg digits.
module bcd_countdown #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       ck,
    input  logic       rs,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] q,
    output logic       running,
    output logic       done,
    output logic [7:0] HEX1,
    output logic [7:0] HEX0
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   pres;
    logic            tick;
    logic            step;

    function automatic logic [3:0] clamp_nib(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] != 4'd0)
            return {v[7:4], v[3:0] - 4'd1};
        else
            return {v[7:4] - 4'd1, 4'd9};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // A tick only takes effect when neither load nor stop outranks it this cycle.
    assign tick    = (state == RUN) && (pres == PW'(TICK_DIV - 1));
    assign step    = tick && !load && !stop;
    assign running = (state == RUN);

    always_ff @(posedge ck) begin
        if (rs)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (load) begin
            state_nx = IDLE;
        end else if (stop) begin
            if (state == RUN)
                state_nx = PAUSE;
        end else if (start && (state == IDLE || state == PAUSE)) begin
            if (q != 8'h00)
                state_nx = RUN;
        end else if (step && q == 8'h01) begin
            state_nx = EXPIRED;
        end
    end

    // Prescaler holds its phase outside RUN so a resume finishes the partial period.
    always_ff @(posedge ck) begin
        if (rs) begin
            q    <= 8'h00;
            pres <= '0;
            done <= 1'b0;
        end else begin
            done <= step && (q == 8'h01);
            if (load) begin
                q    <= {clamp_nib(din[7:4]), clamp_nib(din[3:0])};
                pres <= '0;
            end else begin
                if (step)
                    q <= bcd_dec(q);
                if (state == RUN && !stop)
                    pres <= tick ? '0 : pres + PW'(1);
            end
        end
    end

    always_comb begin
        HEX1 = {1'b1, seg7(q[7:4])};
        HEX0 = {state != PAUSE, seg7(q[3:0])};
        if (state == EXPIRED) begin
            HEX1 = {1'b1, seg7(4'd0)};
            HEX0 = {1'b1, seg7(4'd0)};
        end
    end

endmodule

// File: doc/bcd_countdown.md
Name: bcd_countdown

Overview:
Two-digit BCD countdown timer, the down-counting counterpart of the up-counting BCD display counter. A value is loaded from switches, counted down once per prescaled tick to 00, and then a done pulse fires. The block drives two active-low seven-segment digits directly and sits between board switches/keys and HEX1/HEX0. It is single clock domain: the prescaler produces an enable, not a derived clock.

Parameters:
TICK_DIV, 50000000, ck cycles per count step (1 s at 50 MHz); legal range is 2 or more.

Ports:
ck  input  1  system clock (CLOCK_50)
rs  input  1  synchronous reset, active-high
load  input  1  load din into count; level-sampled each cycle
din  input  8  load value as BCD: [7:4] tens, [3:0] ones
start  input  1  begin or resume counting; level-sampled
stop  input  1  pause counting; level-sampled
q  output  8  current count in BCD, registered
running  output  1  high while in RUN
done  output  1  one-cycle pulse when the count reaches 00
HEX1  output  8  tens digit; active-low segments [6:0], dp [7]
HEX0  output  8  ones digit; active-low segments [6:0], dp [7]

Behaviour:
- One clock domain, ck only. All registers update on posedge ck.
- Reset (rs=1, synchronous, highest priority):
  - state=IDLE, q=8'h00, prescaler=0, done=0, running=0.
  - HEX1=HEX0=8'hC0.
- States: IDLE, RUN, PAUSE, EXPIRED. running = (state==RUN), registered.
- Per-cycle priority: rs > load > stop > start > tick.
- load, in any state:
  - Each nibble of din is clamped: a nibble >9 becomes 9 (8'hA3 loads 8'h93; 8'hFF loads 8'h99).
  - prescaler<=0, state<=IDLE, done<=0.
  - start or stop asserted in the same cycle is ignored.
- start:
  - IDLE or PAUSE -> RUN, but only if q!=8'h00; with q==00 it is ignored and the state is unchanged.
  - Ignored in RUN and in EXPIRED; a load is needed to leave EXPIRED.
- stop:
  - RUN -> PAUSE. The prescaler value is held, not cleared, so resume continues the partial period.
  - No effect in other states.
  - stop and start in the same cycle: stop wins, and the state does not enter RUN that cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and wraps to 0.
  - tick = RUN && prescaler==TICK_DIV-1.
  - The first tick after entering RUN from IDLE occurs TICK_DIV cycles after the start-sampling edge.
- On tick, BCD decrement, with the result registered on the same edge:
  - ones!=0: ones-1.
  - ones==0: ones=9, tens-1.
  - Tens never underflows, because a tick with q==00 cannot occur.
  - If q==8'h01 at the tick: q<=00, state<=EXPIRED, and done=1 for exactly that following cycle, coincident with q first reading 00.
- done: 0 in all other cycles, including reset and load.
- Display decode (combinational from q):
  - 0..9 map to C0,F9,A4,B0,99,92,82,F8,80,90 in the low 7 bits.
  - Nibble >9 cannot occur; it decodes to blank (all segments off).
  - dp bit 7 = 1 (off), except HEX0 bit 7 = 0 while in PAUSE.
  - In EXPIRED, both digits show 0 with dp off.
- Reset mid-count: returns to IDLE with q=00 regardless of state or prescaler phase.
- Load mid-RUN: the count is abandoned, the new value is shown on the next cycle, and counting stops until start.

Test Plan:
Bench uses TICK_DIV=4 throughout.
1. rs for 2 cycles -> q=00, running=0, done=0, HEX1=HEX0=8'hC0; start with q=00 -> stays IDLE.
2. load din=8'h12, then start -> q steps 12,11,10,09,08 every 4 cycles; at the 10->09 step the ones digit borrows to 9 and HEX1=F9 becomes HEX1=C0.
3. load 8'h02, start -> 02,01,00; done high for exactly 1 cycle with q=00; state EXPIRED; further start held 20 cycles -> q stays 00, done stays 0.
4. load 8'h05, start, stop asserted 2 cycles after a tick -> q frozen, HEX0 bit7=0; start 10 cycles later -> next decrement 2 cycles after resume (held phase); start+stop in the same cycle during PAUSE -> stays PAUSE.
5. load 8'hAF -> q=8'h99; load asserted together with start during RUN -> q=new value, running=0.
6. rs asserted mid-RUN on a tick cycle -> q=00, running=0, done=0 on the next edge, with no decrement applied.
